flt2int_iter: RTL

- Parametrised sequential converter from a sign/biased-exponent/fraction float to a saturating two's-complement integer.
- Next-generation hardware replacement for the program-2 float-to-int routine.
- Adds generic widths, selectable rounding (truncate or round-to-nearest-even), saturation and inexact flags.
- Sits beside the core datapath under the core's start/done handshake.

---
 rtl/flt2int_iter_if.sv | 25 ++
 rtl/flt2int_iter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/flt2int_iter_if.sv
// Start/done handshake bundle between the core datapath and the float-to-int converter.
interface flt2int_iter_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int INT_W = 16
);
    logic                   start;
    logic [EXP_W+MAN_W:0]   flt_in;
    logic                   rnd_mode;
    logic [INT_W-1:0]       int_out;
    logic                   sat;
    logic                   inexact;
    logic                   busy;
    logic                   done;

    modport master (
        output start, flt_in, rnd_mode,
        input  int_out, sat, inexact, busy, done
    );

    modport slave (
        input  start, flt_in, rnd_mode,
        output int_out, sat, inexact, busy, done
    );
endinterface

// File: rtl/flt2int_iter.sv
// Iterative float-to-integer converter: decode, shift left one bit per cycle,
// then round (truncate or RNE), saturate and apply the sign.
module flt2int_iter #(
    parameter int EXP_W    = 5,
    parameter int MAN_W    = 10,
    parameter int INT_W    = 16,
    parameter int BIAS     = 2**(EXP_W-1)-1,
    parameter bit ROUND_EN = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    flt2int_iter_if.slave bus
);
    localparam int ACC_W = INT_W + MAN_W;
    localparam int CNT_W = $clog2(INT_W);
    localparam int E_W   = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 2;

    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W:0]   MAG_LIM = {2'b01, {(INT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_SHIFT,
        S_FIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_sign;
    logic [EXP_W-1:0]   r_exp;
    logic [MAN_W-1:0]   r_frac;
    logic               r_rne;
    logic [ACC_W-1:0]   r_acc;
    logic               r_sticky;
    logic               r_trap;
    logic [CNT_W-1:0]   r_cnt;
    logic [INT_W-1:0]   r_int_out;
    logic               r_sat;
    logic               r_inexact;
    logic               r_busy;
    logic               r_done;

    logic [MAN_W:0]     w_sig;
    logic signed [E_W-1:0] w_e;
    logic               w_trap;
    logic [CNT_W-1:0]   w_k;
    logic [ACC_W-1:0]   w_acc_dec;
    logic               w_sticky_dec;
    logic [INT_W-1:0]   w_mag;
    logic               w_guard;
    logic               w_stk;
    logic               w_inc;
    logic [INT_W:0]     w_mag_rnd;
    logic [INT_W-1:0]   w_res;
    logic               w_sat;
    logic               w_inx;

    // Unbiased exponent; the hidden bit is present for every non-zero exponent field.
    assign w_sig  = {|r_exp, r_frac};
    assign w_e    = $signed(E_W'(r_exp)) - $signed(E_W'(BIAS));
    assign w_trap = (&r_exp) | (w_e >= $signed(E_W'(INT_W-1)));
    assign w_k    = (!w_e[E_W-1] && (w_e <= $signed(E_W'(INT_W-2)))) ? w_e[CNT_W-1:0] : '0;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_acc_dec    = ACC_W'(w_sig);
        w_sticky_dec = 1'b0;
        if (w_e == '1) begin
            w_acc_dec    = ACC_W'(w_sig) >> 1;
            w_sticky_dec = w_sig[0];
        end else if (w_e[E_W-1]) begin
            w_acc_dec    = '0;
            w_sticky_dec = |w_sig;
        end
    end

    assign w_mag     = r_acc[ACC_W-1:MAN_W];
    assign w_guard   = r_acc[MAN_W-1];
    assign w_stk     = (|r_acc[MAN_W-2:0]) | r_sticky;
    assign w_inc     = r_rne & w_guard & (w_stk | w_mag[0]);
    assign w_mag_rnd = {1'b0, w_mag} + (INT_W+1)'(w_inc);

    always_comb begin
        w_res = w_mag_rnd[INT_W-1:0];
        w_sat = 1'b0;
        w_inx = w_guard | w_stk;
        if (r_trap) begin
            w_res = r_sign ? INT_MIN : INT_MAX;
            w_sat = 1'b1;
            w_inx = 1'b0;
        end else if (r_sign) begin
            // A magnitude of exactly 2**(INT_W-1) negates onto INT_MIN without clamping.
            w_res = -w_mag_rnd[INT_W-1:0];
        end else if (w_mag_rnd >= MAG_LIM) begin
            w_res = INT_MAX;
            w_sat = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_frac    <= '0;
            r_rne     <= 1'b0;
            r_acc     <= '0;
            r_sticky  <= 1'b0;
            r_trap    <= 1'b0;
            r_cnt     <= '0;
            r_int_out <= '0;
            r_sat     <= 1'b0;
            r_inexact <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_sign  <= bus.flt_in[EXP_W+MAN_W];
                        r_exp   <= bus.flt_in[EXP_W+MAN_W-1:MAN_W];
                        r_frac  <= bus.flt_in[MAN_W-1:0];
                        r_rne   <= ROUND_EN & bus.rnd_mode;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_acc    <= w_acc_dec;
                    r_sticky <= w_sticky_dec;
                    r_trap   <= w_trap;
                    r_cnt    <= w_k;
                    r_state  <= (w_k != '0) ? S_SHIFT : S_FIN;
                end
                S_SHIFT: begin
                    r_acc <= r_acc << 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_int_out <= w_res;
                    r_sat     <= w_sat;
                    r_inexact <= w_inx;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.int_out = r_int_out;
    assign bus.sat     = r_sat;
    assign bus.inexact = r_inexact;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule
